phase_det: RTL

PHASE_DET -- requirements
Module: phase_det

---
 rtl/phase_det_pkg.sv | 26 ++
 rtl/phase_det_edge_sync.sv | 59 +++++
 rtl/phase_det.sv | 133 +++++++++++++
 3 files changed

// File: rtl/phase_det_pkg.sv
// Shared types and constants for the phase detector: FSM states, phase width,
// saturation limits and deglitch depth (deglitch built only with PHASE_DET_DEGLITCH_EN).
package phase_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_V = 2'd2
  } state_t;

  localparam int PHASE_W        = 10;
  localparam int PHASE_MAX      = 511;
  localparam int PHASE_MIN      = -512;
  localparam int DEGLITCH_DEPTH = 4;

  function automatic logic signed [PHASE_W-1:0] sat10(input logic signed [31:0] x);
    if (x > PHASE_MAX) begin
      return PHASE_W'(PHASE_MAX);
    end else if (x < PHASE_MIN) begin
      return PHASE_W'(PHASE_MIN);
    end else begin
      return x[PHASE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/phase_det_edge_sync.sv
// Two-flop synchronizer plus rising-edge pulse; with PHASE_DET_DEGLITCH_EN the
// synchronized level must be stable for DEGLITCH_DEPTH samples before it is accepted.
module edge_sync
  import phase_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1_reg, s2_reg;
  logic lvl, lvl_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
    end
  end

`ifdef PHASE_DET_DEGLITCH_EN
  // Current sample plus the previous DEPTH-1 samples must agree to move the level.
  logic [DEGLITCH_DEPTH-2:0] hist_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= {hist_reg[DEGLITCH_DEPTH-3:0], s2_reg};
    end
  end

  always_comb begin
    lvl = lvl_reg;
    if (&{hist_reg, s2_reg}) begin
      lvl = 1'b1;
    end else if (~|{hist_reg, s2_reg}) begin
      lvl = 1'b0;
    end
  end
`else
  assign lvl = s2_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_reg <= 1'b0;
    end else begin
      lvl_reg <= lvl;
    end
  end

  assign rise = lvl & ~lvl_reg;

endmodule

// File: rtl/phase_det.sv
// Voltage/current zero-cross phase detector: measures edge-to-edge lag in clocks,
// publishes a saturated phase on each tick, flags timeouts and loss of signal.
module phase_det
  import phase_det_pkg::*;
#(
  parameter int CNT_W     = 12,
  parameter int SHIFT     = 2,
  parameter int TIMEOUT   = 2047,
  parameter int LOS_TICKS = 16
) (
  input  logic                      clk50MHz,
  input  logic                      rst,
  input  logic                      tick60k,
  input  logic                      v_sq,
  input  logic                      i_sq,
  output logic signed [PHASE_W-1:0] phase,
  output logic                      valid,
  output logic                      los,
  output logic                      to_err
);

  localparam int LOS_W = $clog2(LOS_TICKS + 1);

  logic [1:0] sq;
  logic [1:0] rise;
  logic       v_rise, i_rise;

  assign sq = {i_sq, v_sq};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      edge_sync u_edge_sync (
        .clk  (clk50MHz),
        .rst  (rst),
        .din  (sq[gi]),
        .rise (rise[gi])
      );
    end
  endgenerate

  assign v_rise = rise[0];
  assign i_rise = rise[1];

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic signed [CNT_W:0]   meas_reg, meas_next;
  logic [CNT_W:0]          mag;
  logic                    new_meas, timeout, closing, opening;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    meas_next  = meas_reg;
    new_meas   = 1'b0;
    timeout    = 1'b0;
    closing    = (state_reg == WAIT_I) ? i_rise : v_rise;
    opening    = (state_reg == WAIT_I) ? v_rise : i_rise;
    // Closing edge arrives N cycles after the opening one, while cnt holds N-1.
    mag        = {1'b0, cnt_reg} + (CNT_W+1)'(1);
    case (state_reg)
      IDLE: begin
        if (v_rise && i_rise) begin
          meas_next = '0;
          new_meas  = 1'b1;
        end else if (v_rise) begin
          state_next = WAIT_I;
          cnt_next   = '0;
        end else if (i_rise) begin
          state_next = WAIT_V;
          cnt_next   = '0;
        end
      end
      WAIT_I, WAIT_V: begin
        if (cnt_reg == CNT_W'(TIMEOUT)) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end else if (closing) begin
          meas_next  = (state_reg == WAIT_I) ? $signed(mag) : -$signed(mag);
          new_meas   = 1'b1;
          state_next = IDLE;
        end else if (opening) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [LOS_W-1:0]      loss_reg, loss_next;
  logic                  los_hit;
  logic signed [CNT_W:0] shifted;
  logic signed [31:0]    wide;

  always_comb begin
    loss_next = loss_reg;
    if (new_meas) begin
      loss_next = '0;
    end else if (tick60k && (loss_reg != LOS_W'(LOS_TICKS))) begin
      loss_next = loss_reg + LOS_W'(1);
    end
  end

  assign los_hit = (loss_next == LOS_W'(LOS_TICKS));
  // A measurement completing on the tick cycle is published immediately.
  assign shifted = meas_next >>> SHIFT;
  assign wide    = shifted;
  assign los     = (loss_reg == LOS_W'(LOS_TICKS));

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      meas_reg  <= '0;
      loss_reg  <= '0;
      phase     <= '0;
      valid     <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      meas_reg  <= meas_next;
      loss_reg  <= loss_next;
      valid     <= tick60k;
      to_err    <= timeout;
      if (tick60k) begin
        phase <= los_hit ? '0 : sat10(wide);
      end
    end
  end

endmodule
